// File: rtl/log_lut_pkg.sv
// rtl/log_lut_pkg.sv - register map, control bits and state type for the log LUT loader
package log_lut_pkg;

  // Slot register offsets
  localparam logic [4:0] REG_CTRL       = 5'd0;
  localparam logic [4:0] REG_STATUS     = 5'd0;
  localparam logic [4:0] REG_PTR        = 5'd1;
  localparam logic [4:0] REG_DATA       = 5'd2;
  localparam logic [4:0] REG_FILL_COUNT = 5'd3;
  localparam logic [4:0] REG_FILL_VALUE = 5'd4;

  // CTRL write bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // STATUS read bits
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/log_lut_loader_if.sv
// rtl/log_lut_loader_if.sv - MMIO slot bus between the slot decoder and the LUT loader
interface log_lut_loader_if;

  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/log_lut_loader.sv
// rtl/log_lut_loader.sv - MMIO-driven writer for the log LUT RAM with single-entry and fill modes
module log_lut_loader
  import log_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  log_lut_loader_if.slave       bus,
  output logic                  lut_we,
  output logic [ADDR_WIDTH-1:0] lut_addr_w,
  output logic [DATA_WIDTH-1:0] lut_din
);

  // A count of exactly the table depth rewrites every entry once
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   fill_count;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  done;

  logic                  busy;
  logic                  wr_en;
  logic                  ctrl_wr;
  logic                  abort_req;
  logic                  start_req;
  logic [ADDR_WIDTH:0]   count_in;
  logic                  unused_slot;

  assign busy      = (state == FILL);
  assign wr_en     = bus.cs && bus.write;
  assign ctrl_wr   = wr_en && (bus.addr == REG_CTRL);
  assign abort_req = ctrl_wr && bus.wr_data[CTRL_ABORT_BIT];
  // Abort in the same CTRL write suppresses the start
  assign start_req = ctrl_wr && bus.wr_data[CTRL_START_BIT] && !bus.wr_data[CTRL_ABORT_BIT];

  // Reads have no side effects and the upper data bits carry nothing for this table
  assign unused_slot = ^{bus.read, bus.wr_data[31:ADDR_WIDTH+1]};

  // Fill count arrives as ADDR_WIDTH+1 bits and never exceeds the table depth
  always_comb begin
    count_in = bus.wr_data[ADDR_WIDTH:0];
    if (count_in > FULL_COUNT) begin
      count_in = FULL_COUNT;
    end
  end

  // Slot read mux; reads are purely combinational on addr
  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      REG_STATUS:     bus.rd_data = 32'({done, busy});
      REG_PTR:        bus.rd_data = 32'(ptr);
      REG_FILL_COUNT: bus.rd_data = 32'(fill_count);
      REG_FILL_VALUE: bus.rd_data = 32'(fill_value);
      default:        bus.rd_data = '0;
    endcase
  end

  // Slot register file, fill FSM and registered LUT write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      fill_count <= '0;
      fill_value <= '0;
      remaining  <= '0;
      done       <= 1'b0;
      lut_we     <= 1'b0;
      lut_addr_w <= '0;
      lut_din    <= '0;
    end else begin
      lut_we <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            case (bus.addr)
              REG_CTRL: begin
                if (start_req) begin
                  // A zero-length fill completes immediately without touching the LUT
                  done <= (fill_count == '0);
                  if (fill_count != '0) begin
                    // First entry is issued on the start edge, so remaining
                    // counts the writes still owed after this one
                    state      <= FILL;
                    lut_we     <= 1'b1;
                    lut_addr_w <= ptr;
                    lut_din    <= fill_value;
                    ptr        <= ptr + 1'b1;
                    remaining  <= fill_count - 1'b1;
                  end
                end
              end
              REG_PTR:        ptr        <= bus.wr_data[ADDR_WIDTH-1:0];
              REG_DATA: begin
                lut_we     <= 1'b1;
                lut_addr_w <= ptr;
                lut_din    <= bus.wr_data[DATA_WIDTH-1:0];
                ptr        <= ptr + 1'b1;
              end
              REG_FILL_COUNT: fill_count <= count_in;
              REG_FILL_VALUE: fill_value <= bus.wr_data[DATA_WIDTH-1:0];
              default: ;
            endcase
          end
        end
        FILL: begin
          if (abort_req) begin
            // Abort leaves done clear and ptr at the next unwritten entry
            state <= IDLE;
          end else if (remaining == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            lut_we     <= 1'b1;
            lut_addr_w <= ptr;
            lut_din    <= fill_value;
            ptr        <= ptr + 1'b1;
            remaining  <= remaining - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_lut_loader.sv
// tb/tb_log_lut_loader.sv - self-checking bench for log_lut_loader
module tb_log_lut_loader;
  import log_lut_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lut_we;
  logic [AW-1:0] lut_addr_w;
  logic [DW-1:0] lut_din;

  log_lut_loader_if bus();

  log_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .lut_we     (lut_we),
    .lut_addr_w (lut_addr_w),
    .lut_din    (lut_din)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int d; int c; } seen_t;
  typedef struct { int a; int d; } exp_t;

  seen_t seen_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_wr_cyc = 0;
  int    ptr_m = 0;
  int    hits[DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && lut_we) seen_q.push_back('{int'(lut_addr_w), int'(lut_din), cyc});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.read = 1'b0; bus.addr = a; bus.wr_data = d;
    last_wr_cyc = cyc;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = a;
    #1 d = bus.rd_data;
  endtask

  task automatic wait_idle(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = REG_STATUS;
      #1;
      if (bus.rd_data[STATUS_BUSY_BIT] == 1'b0) begin
        at = cyc;
        break;
      end
    end
    chk("wait_idle_bound", 32'(at >= 0), 32'd1);
  endtask

  task automatic set_ptr(input int p);
    bus_wr(REG_PTR, 32'(p));
    ptr_m = p;
  endtask

  task automatic push_data(input int d);
    exp_q.push_back('{ptr_m, d});
    ptr_m = (ptr_m + 1) % DEPTH;
  endtask

  task automatic push_fill(input int cnt, input int v);
    for (int i = 0; i < cnt; i++) exp_q.push_back('{(ptr_m + i) % DEPTH, v});
    ptr_m = (ptr_m + cnt) % DEPTH;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(seen_q[i].a), 32'(exp_q[i].a));
      chk({tag, "_din"},  32'(seen_q[i].d), 32'(exp_q[i].d));
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] rv;
    int c0;
    int at;
    int start_p;
    int fv;
    int ok_cnt;

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_lut_we", 32'(lut_we), 32'd0);
    chk("rst_lut_addr", 32'(lut_addr_w), 32'd0);
    chk("rst_lut_din", 32'(lut_din), 32'd0);
    reset_n = 1'b1;
    bus_rd(REG_STATUS, rv);     chk("rst_status", rv, 32'd0);
    bus_rd(REG_PTR, rv);        chk("rst_ptr", rv, 32'd0);
    bus_rd(REG_FILL_COUNT, rv); chk("rst_fill_count", rv, 32'd0);
    bus_rd(REG_FILL_VALUE, rv); chk("rst_fill_value", rv, 32'd0);
    bus_rd(5'd2, rv);           chk("unmapped_read", rv, 32'd0);

    // Back-to-back single-entry writes
    set_ptr(5);
    bus_wr(REG_DATA, 32'hFFFF_FFF3); push_data(3); c0 = last_wr_cyc;
    bus_wr(REG_DATA, 32'd1);         push_data(1);
    bus_idle(); bus_idle();
    chk("data_latency", 32'(seen_q.size() > 0 ? seen_q[0].c : -1), 32'(c0 + 1));
    chk("data_b2b", 32'(seen_q.size() > 1 ? seen_q[1].c - seen_q[0].c : -1), 32'd1);
    compare_writes("data");
    bus_rd(REG_PTR, rv); chk("data_ptr", rv, 32'(ptr_m));

    // Pointer wrap
    set_ptr(1023);
    bus_wr(REG_DATA, 32'd2); push_data(2);
    bus_wr(REG_DATA, 32'd1); push_data(1);
    bus_idle(); bus_idle();
    compare_writes("wrap");
    bus_rd(REG_PTR, rv); chk("wrap_ptr", rv, 32'd1);

    // Eight-entry fill
    set_ptr(100);
    bus_wr(REG_FILL_VALUE, 32'd2);
    bus_wr(REG_FILL_COUNT, 32'd8);
    bus_wr(REG_CTRL, 32'd1); c0 = last_wr_cyc;
    push_fill(8, 2);
    wait_idle(40, at);
    chk("fill_idle_cycle", 32'(at), 32'(c0 + 9));
    chk("fill_first_cycle", 32'(seen_q.size() > 0 ? seen_q[0].c : -1), 32'(c0 + 1));
    chk("fill_last_cycle", 32'(seen_q.size() > 7 ? seen_q[7].c : -1), 32'(c0 + 8));
    compare_writes("fill8");
    bus_rd(REG_STATUS, rv); chk("fill_status", rv, 32'd2);
    bus_rd(REG_PTR, rv);    chk("fill_ptr", rv, 32'd108);

    // Full-count fill aborted after ten writes; slot writes during the fill are ignored
    set_ptr(512);
    bus_wr(REG_FILL_VALUE, 32'd1);
    bus_wr(REG_FILL_COUNT, 32'd1024);
    bus_wr(REG_CTRL, 32'd1); c0 = last_wr_cyc;
    bus_idle();
    bus_wr(REG_DATA, 32'd3);
    bus_wr(REG_PTR, 32'd7);
    bus_wr(REG_FILL_VALUE, 32'd3);
    repeat (5) bus_idle();
    bus_wr(REG_CTRL, 32'd2);
    chk("abort_issue_cycle", 32'(last_wr_cyc), 32'(c0 + 10));
    push_fill(10, 1);
    wait_idle(20, at);
    chk("abort_idle_cycle", 32'(at), 32'(c0 + 11));
    compare_writes("abort");
    bus_rd(REG_STATUS, rv);     chk("abort_status", rv, 32'd0);
    bus_rd(REG_PTR, rv);        chk("abort_ptr", rv, 32'd522);
    bus_rd(REG_FILL_COUNT, rv); chk("abort_fill_count", rv, 32'd1024);
    bus_rd(REG_FILL_VALUE, rv); chk("abort_fill_value", rv, 32'd1);

    // Start and abort together: nothing starts
    bus_wr(REG_FILL_COUNT, 32'd5);
    bus_wr(REG_CTRL, 32'd3);
    repeat (3) bus_idle();
    compare_writes("start_abort");
    bus_rd(REG_STATUS, rv); chk("start_abort_status", rv, 32'd0);

    // Zero-count fill sets done one cycle later with no LUT writes
    bus_wr(REG_FILL_COUNT, 32'd0);
    bus_wr(REG_CTRL, 32'd1);
    bus_rd(REG_STATUS, rv); chk("zero_status", rv, 32'd2);
    repeat (3) bus_idle();
    compare_writes("zero");

    // Whole-table fill from a random start
    start_p = int'($urandom_range(0, DEPTH - 1));
    fv = int'($urandom_range(0, 3));
    set_ptr(start_p);
    bus_wr(REG_FILL_VALUE, 32'(fv));
    bus_wr(REG_FILL_COUNT, 32'd1024);
    bus_wr(REG_CTRL, 32'd1);
    wait_idle(1100, at);
    for (int i = 0; i < DEPTH; i++) hits[i] = 0;
    ok_cnt = 0;
    foreach (seen_q[i]) begin
      hits[seen_q[i].a]++;
      if (seen_q[i].d == fv) ok_cnt++;
    end
    chk("full_count", 32'(seen_q.size()), 32'(DEPTH));
    chk("full_value", 32'(ok_cnt), 32'(DEPTH));
    ok_cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (hits[i] == 1) ok_cnt++;
    chk("full_cover", 32'(ok_cnt), 32'(DEPTH));
    seen_q.delete();
    bus_rd(REG_PTR, rv);    chk("full_ptr", rv, 32'(start_p));
    bus_rd(REG_STATUS, rv); chk("full_status", rv, 32'd2);

    // Randomized mix of pointer moves, data bursts and short fills
    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        set_ptr(r == 0 ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, DEPTH - 1)));
      end else if (r <= 6) begin
        int n;
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) begin
          logic [31:0] d;
          d = $urandom;
          bus_wr(REG_DATA, d);
          push_data(int'(d[1:0]));
        end
        bus_idle();
      end else if (r <= 8) begin
        int n;
        logic [31:0] v;
        n = int'($urandom_range(0, 30));
        v = $urandom;
        bus_wr(REG_FILL_VALUE, v);
        bus_wr(REG_FILL_COUNT, 32'(n));
        bus_wr(REG_CTRL, 32'd1);
        push_fill(n, int'(v[1:0]));
        wait_idle(60, at);
      end else begin
        bus_rd(REG_PTR, rv); chk("rand_ptr", rv, 32'(ptr_m));
      end
    end
    bus_idle(); bus_idle();
    compare_writes("rand");
    bus_rd(REG_PTR, rv); chk("rand_final_ptr", rv, 32'(ptr_m));

    // Asynchronous reset during a fill
    bus_wr(REG_FILL_VALUE, 32'd3);
    bus_wr(REG_FILL_COUNT, 32'd50);
    bus_wr(REG_CTRL, 32'd1);
    repeat (5) bus_idle();
    @(posedge clk);
    #2;
    chk("pre_reset_we", 32'(lut_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_we_now", 32'(lut_we), 32'd0);
    chk("reset_addr_now", 32'(lut_addr_w), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen_q.delete();
    bus_rd(REG_STATUS, rv);     chk("post_rst_status", rv, 32'd0);
    bus_rd(REG_PTR, rv);        chk("post_rst_ptr", rv, 32'd0);
    bus_rd(REG_FILL_COUNT, rv); chk("post_rst_fill_count", rv, 32'd0);
    bus_rd(REG_FILL_VALUE, rv); chk("post_rst_fill_value", rv, 32'd0);
    chk("post_rst_din", 32'(lut_din), 32'd0);
    repeat (3) bus_idle();
    chk("post_rst_writes", 32'(seen_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
